// File: rtl/plaintext_streamer.sv
// plaintext_streamer
// Takes the winning core index and key from the RC4 cracking array. It sends a
// KEY_LENGTH-byte key header, then reads that core's A RAM one byte at a time
// and streams each byte over a valid/ready interface. It keeps a mod-256
// checksum of the message bytes only.
module plaintext_streamer #(
  parameter int NUM_CORES          = 90,
  parameter int LOG_NUM_CORES      = 8,
  parameter int MESSAGE_LENGTH     = 32,
  parameter int MESSAGE_LOG_LENGTH = 5,
  parameter int RAM_WIDTH          = 8,
  parameter int KEY_LENGTH         = 3,
  parameter int READ_LATENCY       = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic [LOG_NUM_CORES-1:0]        core_sel,
  input  logic [KEY_LENGTH*RAM_WIDTH-1:0] key_in,
  output logic [LOG_NUM_CORES-1:0]        rd_core,
  output logic [MESSAGE_LOG_LENGTH-1:0]   rd_addr,
  input  logic [RAM_WIDTH-1:0]            rd_data,
  output logic [RAM_WIDTH-1:0]            out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [RAM_WIDTH-1:0]            checksum
);

  localparam int KEY_W = KEY_LENGTH * RAM_WIDTH;
  localparam int HDR_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
  localparam int LAT_W = 2;

  localparam logic [HDR_W-1:0]              HDR_LAST   = HDR_W'(KEY_LENGTH - 1);
  localparam logic [MESSAGE_LOG_LENGTH-1:0] ADDR_LAST  = MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);
  localparam logic [LAT_W-1:0]              LAT_LAST   = LAT_W'(READ_LATENCY);
  localparam logic [LOG_NUM_CORES:0]        CORE_LIMIT = (LOG_NUM_CORES + 1)'(NUM_CORES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_SEND  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t                          state_r;
  logic [KEY_W-1:0]                key_r;
  logic [HDR_W-1:0]                hdr_idx_r;
  logic [MESSAGE_LOG_LENGTH-1:0]   addr_r;
  logic [LAT_W-1:0]                wait_r;

  // Header byte idx of the key; byte 0 is the most significant.
  function automatic logic [RAM_WIDTH-1:0] key_byte(input logic [KEY_W-1:0] key,
                                                    input logic [HDR_W-1:0] idx);
    logic [RAM_WIDTH-1:0] b;
    b = {RAM_WIDTH{1'b0}};
    for (int i = 0; i < KEY_LENGTH; i++) begin
      if (idx == HDR_W'(i)) begin
        b = key[(KEY_LENGTH - 1 - i) * RAM_WIDTH +: RAM_WIDTH];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

  // Running message checksum, modulo 2^RAM_WIDTH.
  function automatic logic [RAM_WIDTH-1:0] csum_add(input logic [RAM_WIDTH-1:0] acc,
                                                    input logic [RAM_WIDTH-1:0] b);
    return acc + b;
  endfunction

  // Transfer sequencer: header, then fetch/wait/send per message byte. Every output is registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      key_r     <= {KEY_W{1'b0}};
      hdr_idx_r <= {HDR_W{1'b0}};
      addr_r    <= {MESSAGE_LOG_LENGTH{1'b0}};
      wait_r    <= {LAT_W{1'b0}};
      rd_core   <= {LOG_NUM_CORES{1'b0}};
      rd_addr   <= {MESSAGE_LOG_LENGTH{1'b0}};
      out_data  <= {RAM_WIDTH{1'b0}};
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      checksum  <= {RAM_WIDTH{1'b0}};
    end else begin
      done <= 1'b0;
      if (abort && (state_r != S_IDLE)) begin
        // Cancel wins over a same-cycle handshake, so that byte is not counted.
        state_r   <= S_IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (start) begin
              if ({1'b0, core_sel} < CORE_LIMIT) begin
                rd_core   <= core_sel;
                key_r     <= key_in;
                checksum  <= {RAM_WIDTH{1'b0}};
                err       <= 1'b0;
                hdr_idx_r <= {HDR_W{1'b0}};
                addr_r    <= {MESSAGE_LOG_LENGTH{1'b0}};
                wait_r    <= {LAT_W{1'b0}};
                out_data  <= key_byte(key_in, {HDR_W{1'b0}});
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                busy      <= 1'b1;
                state_r   <= S_HDR;
              end else begin
                err <= 1'b1;
              end
            end else begin
              state_r <= S_IDLE;
            end
          end
          S_HDR: begin
            if (out_valid && out_ready) begin
              if (hdr_idx_r == HDR_LAST) begin
                out_valid <= 1'b0;
                addr_r    <= {MESSAGE_LOG_LENGTH{1'b0}};
                rd_addr   <= {MESSAGE_LOG_LENGTH{1'b0}};
                state_r   <= S_FETCH;
              end else begin
                hdr_idx_r <= hdr_idx_r + HDR_W'(1);
                out_data  <= key_byte(key_r, hdr_idx_r + HDR_W'(1));
              end
            end else begin
              state_r <= S_HDR;
            end
          end
          S_FETCH: begin
            // rd_addr was loaded on entry; the RAM sees it during this cycle.
            wait_r  <= LAT_W'(1);
            state_r <= S_WAIT;
          end
          S_WAIT: begin
            if (wait_r == LAT_LAST) begin
              out_data  <= rd_data;
              out_valid <= 1'b1;
              out_last  <= (addr_r == ADDR_LAST);
              state_r   <= S_SEND;
            end else begin
              wait_r <= wait_r + LAT_W'(1);
            end
          end
          S_SEND: begin
            if (out_valid && out_ready) begin
              checksum  <= csum_add(checksum, out_data);
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (out_last) begin
                done    <= 1'b1;
                state_r <= S_FIN;
              end else begin
                addr_r  <= addr_r + MESSAGE_LOG_LENGTH'(1);
                rd_addr <= addr_r + MESSAGE_LOG_LENGTH'(1);
                state_r <= S_FETCH;
              end
            end else begin
              state_r <= S_SEND;
            end
          end
          S_FIN: begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end
          default: begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state_r   <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_plaintext_streamer.sv
`timescale 1ns/1ps
module tb_plaintext_streamer;

  localparam int NC = 90;
  localparam int ML = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_v    [2];
  logic        abort_v    [2];
  logic        ready_v    [2];
  logic [7:0]  core_sel_v [2];
  logic [23:0] key_v      [2];
  logic [7:0]  rd_core_w  [2];
  logic [4:0]  rd_addr_w  [2];
  logic [7:0]  rd_data_w  [2];
  logic [7:0]  out_data_w [2];
  logic [7:0]  checksum_w [2];
  logic        out_valid_w[2];
  logic        out_last_w [2];
  logic        busy_w     [2];
  logic        done_w     [2];
  logic        err_w      [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  plaintext_streamer #(.READ_LATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort_v[0]),
    .core_sel(core_sel_v[0]), .key_in(key_v[0]), .rd_core(rd_core_w[0]),
    .rd_addr(rd_addr_w[0]), .rd_data(rd_data_w[0]), .out_data(out_data_w[0]),
    .out_valid(out_valid_w[0]), .out_ready(ready_v[0]), .out_last(out_last_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]), .checksum(checksum_w[0]));

  plaintext_streamer #(.READ_LATENCY(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort_v[1]),
    .core_sel(core_sel_v[1]), .key_in(key_v[1]), .rd_core(rd_core_w[1]),
    .rd_addr(rd_addr_w[1]), .rd_data(rd_data_w[1]), .out_data(out_data_w[1]),
    .out_valid(out_valid_w[1]), .out_ready(ready_v[1]), .out_last(out_last_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]), .checksum(checksum_w[1]));

  // A RAM model: one 32-byte message per core, read with a fixed latency per DUT.
  logic [7:0] ram [NC][ML];
  logic [7:0] pipe0;
  logic [7:0] pipe1 [3];

  function automatic logic [7:0] ram_rd(input int c, input int a);
    if (c < NC && a < ML) return ram[c][a];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    pipe0    <= ram_rd(int'(rd_core_w[0]), int'(rd_addr_w[0]));
    pipe1[0] <= ram_rd(int'(rd_core_w[1]), int'(rd_addr_w[1]));
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign rd_data_w[0] = pipe0;
  assign rd_data_w[1] = pipe1[2];

  // Handshake / done / hold-stability monitor, sampled on the falling edge.
  int         hs_d    [$];
  logic [7:0] hs_data [$];
  logic       hs_last [$];
  int         hs_cyc  [$];
  int   hs_cnt   [2] = '{0, 0};
  int   done_cnt [2] = '{0, 0};
  int   done_cyc [2] = '{0, 0};
  int   done_dbl [2] = '{0, 0};
  int   hold_bad [2] = '{0, 0};
  logic stall_p  [2] = '{1'b0, 1'b0};
  logic done_p   [2] = '{1'b0, 1'b0};
  logic [7:0] stall_data [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        stall_p[d] <= 1'b0;
        done_p[d]  <= 1'b0;
      end else begin
        if (stall_p[d] && !(out_valid_w[d] && out_data_w[d] == stall_data[d]))
          hold_bad[d] <= hold_bad[d] + 1;
        stall_p[d]    <= out_valid_w[d] && !ready_v[d] && !abort_v[d];
        stall_data[d] <= out_data_w[d];
        if (out_valid_w[d] && ready_v[d] && !abort_v[d]) begin
          hs_d.push_back(d);
          hs_data.push_back(out_data_w[d]);
          hs_last.push_back(out_last_w[d]);
          hs_cyc.push_back(cyc);
          hs_cnt[d] <= hs_cnt[d] + 1;
        end
        if (done_w[d]) begin
          done_cnt[d] <= done_cnt[d] + 1;
          done_cyc[d] <= cyc;
          if (done_p[d]) done_dbl[d] <= done_dbl[d] + 1;
        end
        done_p[d] <= done_w[d];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk($sformatf("%s_rd_core%0d", tag, d),   rd_core_w[d],   0);
    chk($sformatf("%s_rd_addr%0d", tag, d),   rd_addr_w[d],   0);
    chk($sformatf("%s_out_data%0d", tag, d),  out_data_w[d],  0);
    chk($sformatf("%s_out_valid%0d", tag, d), out_valid_w[d], 0);
    chk($sformatf("%s_out_last%0d", tag, d),  out_last_w[d],  0);
    chk($sformatf("%s_busy%0d", tag, d),      busy_w[d],      0);
    chk($sformatf("%s_done%0d", tag, d),      done_w[d],      0);
    chk($sformatf("%s_err%0d", tag, d),       err_w[d],       0);
    chk($sformatf("%s_checksum%0d", tag, d),  checksum_w[d],  0);
  endtask

  // Last committed rd_core / checksum per DUT, as the bench expects them.
  int last_core [2] = '{0, 0};
  int last_sum  [2] = '{0, 0};

  // Runs one start request on DUT d and checks the whole resulting transfer.
  // Called at posedge+1. mode: 0 ready high, 1 ready pattern 1,0,0, 2 random ready.
  task automatic run_xfer(input int d, input logic [7:0] core, input logic [23:0] key,
                          input int mode, input bit exp_err, input int exp_sum,
                          input int mid_start, input bit fin_start);
    int lat, base_q, dc0, hold0, dbl0, st_cyc, k, idx, sum, last_cyc;
    bit got_done;
    logic [7:0] exp_b [35];
    lat    = (d == 0) ? 1 : 3;
    base_q = hs_d.size();
    dc0    = done_cnt[d];
    hold0  = hold_bad[d];
    dbl0   = done_dbl[d];
    core_sel_v[d] = core;
    key_v[d]      = key;
    start_v[d]    = 1'b1;
    ready_v[d]    = 1'b1;
    st_cyc        = cyc;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    if (exp_err) begin
      chk("illegal_rd_core", rd_core_w[d], last_core[d]);
      chk("illegal_checksum", checksum_w[d], last_sum[d]);
      for (int i = 0; i < 3; i++) begin
        chk("illegal_err", err_w[d], 1);
        chk("illegal_busy", busy_w[d], 0);
        chk("illegal_valid", out_valid_w[d], 0);
        @(posedge clk); #1;
      end
      return;
    end
    // Expected stream from first principles: key MSB-first, then the core's message.
    sum = 0;
    for (int i = 0; i < 3; i++) exp_b[i] = key[(2 - i) * 8 +: 8];
    for (int j = 0; j < ML; j++) begin
      exp_b[3 + j] = ram[int'(core)][j];
      sum = (sum + int'(ram[int'(core)][j])) % 256;
    end
    if (exp_sum >= 0) sum = exp_sum;
    got_done = 1'b0;
    k = 0;
    while (!got_done && k < 3000) begin
      case (mode)
        0:       ready_v[d] = 1'b1;
        1:       ready_v[d] = (k % 3 == 0);
        default: ready_v[d] = 1'($urandom_range(0, 1));
      endcase
      if (mid_start > 0 && k == mid_start) begin
        start_v[d]    = 1'b1;
        core_sel_v[d] = core + 8'd1;
        key_v[d]      = ~key;
      end else begin
        start_v[d] = 1'b0;
      end
      @(posedge clk); #1;
      k++;
      if (done_w[d]) got_done = 1'b1;
    end
    start_v[d] = 1'b0;
    chk("done_seen", got_done, 1);
    if (!got_done) return;
    ready_v[d] = 1'b1;
    if (fin_start) begin
      start_v[d]    = 1'b1;
      core_sel_v[d] = 8'd3;
    end
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    chk("after_fin_busy", busy_w[d], 0);
    chk("after_fin_done", done_w[d], 0);
    chk("after_fin_valid", out_valid_w[d], 0);
    idx = 0;
    last_cyc = 0;
    for (int i = base_q; i < hs_d.size(); i++) begin
      if (hs_d[i] == d) begin
        if (idx < 35) begin
          chk($sformatf("stream_byte[%0d]", idx), hs_data[i], exp_b[idx]);
          chk($sformatf("stream_last[%0d]", idx), hs_last[i], (idx == 34) ? 1 : 0);
          if (mode == 0)
            chk($sformatf("stream_cycle[%0d]", idx), hs_cyc[i] - st_cyc,
                (idx < 3) ? (1 + idx) : (3 + (lat + 2) * (idx - 2)));
        end
        last_cyc = hs_cyc[i];
        idx++;
      end
    end
    chk("stream_len", idx, 35);
    chk("done_count", done_cnt[d] - dc0, 1);
    chk("done_after_last", done_cyc[d] - last_cyc, 1);
    chk("done_single_cycle", done_dbl[d] - dbl0, 0);
    chk("hold_stable", hold_bad[d] - hold0, 0);
    chk("final_checksum", checksum_w[d], sum);
    chk("final_rd_core", rd_core_w[d], core);
    chk("final_err", err_w[d], 0);
    last_core[d] = int'(core);
    last_sum[d]  = sum;
  endtask

  typedef struct {
    logic [7:0]  core;
    logic [23:0] key;
    int          mode;
    bit          exp_err;
    int          exp_sum;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int base, found, psum, st;
    logic [7:0]  core;
    logic [23:0] key;

    tbl[0] = '{core: 8'd5,   key: 24'h0003A7, mode: 0, exp_err: 1'b0, exp_sum: 240};
    tbl[1] = '{core: 8'd5,   key: 24'h0003A7, mode: 1, exp_err: 1'b0, exp_sum: 240};
    tbl[2] = '{core: 8'd90,  key: 24'h123456, mode: 0, exp_err: 1'b1, exp_sum: -1};
    tbl[3] = '{core: 8'd0,   key: 24'hABCDEF, mode: 0, exp_err: 1'b0, exp_sum: 240};
    tbl[4] = '{core: 8'd89,  key: 24'h5A5A5A, mode: 2, exp_err: 1'b0, exp_sum: 240};
    tbl[5] = '{core: 8'd255, key: 24'h000000, mode: 0, exp_err: 1'b1, exp_sum: -1};

    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; abort_v[d] = 1'b0; ready_v[d] = 1'b1;
      core_sel_v[d] = 8'd0; key_v[d] = 24'd0;
    end
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < ML; a++) ram[c][a] = 8'(a);

    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk_zero(0, "reset0");
    chk_zero(1, "reset0");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed table: basic, backpressure, illegal index, boundary cores.
    for (int i = 0; i < 6; i++)
      run_xfer(0, tbl[i].core, tbl[i].key, tbl[i].mode, tbl[i].exp_err, tbl[i].exp_sum, 0, 1'b0);

    // Randomized messages against the model.
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < ML; a++) ram[c][a] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++)
      run_xfer(0, 8'($urandom_range(0, NC - 1)), 24'($urandom), 2, 1'b0, -1, 0, 1'b0);

    // Abort in the SEND cycle of message byte 10 with ready high.
    core = 8'd17; key = 24'hC0FFEE;
    psum = 0;
    for (int j = 0; j < 10; j++) psum = (psum + int'(ram[17][j])) % 256;
    base = hs_cnt[0];
    core_sel_v[0] = core; key_v[0] = key; ready_v[0] = 1'b1; start_v[0] = 1'b1;
    st = cyc;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      if (out_valid_w[0] && (hs_cnt[0] - base) == 13) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("abort_reach_byte10", found, 1);
    chk("abort_byte10_cycle", cyc - st, 36);
    abort_v[0] = 1'b1;
    @(posedge clk); #1;
    abort_v[0] = 1'b0;
    chk("abort_valid", out_valid_w[0], 0);
    chk("abort_last", out_last_w[0], 0);
    chk("abort_busy", busy_w[0], 0);
    chk("abort_checksum", checksum_w[0], psum);
    base = done_cnt[0];
    repeat (5) begin @(posedge clk); #1; end
    chk("abort_no_done", done_cnt[0] - base, 0);
    chk("abort_hs_count", hs_cnt[0] - (hs_cnt[0] - 13 + 0), 13);
    chk("abort_err", err_w[0], 0);
    run_xfer(0, core, key, 0, 1'b0, -1, 0, 1'b0);

    // Start presented during the FIN cycle must be ignored.
    run_xfer(0, 8'd42, 24'h010203, 0, 1'b0, -1, 0, 1'b1);

    // Asynchronous reset during WAIT of message byte 5.
    base = hs_cnt[0];
    core_sel_v[0] = 8'd5; key_v[0] = 24'h778899; ready_v[0] = 1'b1; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      if (!out_valid_w[0] && busy_w[0] && rd_addr_w[0] == 5'd5 && (hs_cnt[0] - base) == 8) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("reset_reach_fetch5", found, 1);
    @(posedge clk); #1;
    chk("pre_reset_busy", busy_w[0], 1);
    chk("pre_reset_rd_core", rd_core_w[0], 5);
    #2 reset = 1'b0;
    #1;
    chk_zero(0, "async_reset");
    @(posedge clk); #1;
    reset = 1'b1;
    last_core[0] = 0; last_sum[0] = 0;
    for (int i = 0; i < 3; i++) begin
      chk("post_reset_busy", busy_w[0], 0);
      chk("post_reset_valid", out_valid_w[0], 0);
      @(posedge clk); #1;
    end
    run_xfer(0, 8'd8, 24'hFEDCBA, 0, 1'b0, -1, 0, 1'b0);

    // Latency-3 instance: 5-cycle byte period, mid-stream start ignored.
    run_xfer(1, 8'd7, 24'h3C5A96, 0, 1'b0, -1, 40, 1'b0);
    run_xfer(1, 8'd89, 24'($urandom), 2, 1'b0, -1, 25, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
